// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment display path: active-low hex codes
// and the all-off values for segments and anodes.
package seg7_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [3:0] AN_OFF    = 4'hF;

  // Active-low {g,f,e,d,c,b,a}; entry 15 is first in the concatenation.
  localparam logic [15:0][6:0] HEX_SEG7 = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-low seven-segment code lookup.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  assign o_seg = HEX_SEG7[i_nib];

endmodule

// File: rtl/rev_counter_display.sv
// Four-digit multiplexed hex display for the reversible counter, with a
// frame-synchronous shadow capture and a stretched ripple-carry LED.
module rev_counter_display
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100000,
  parameter int unsigned STRETCH  = 25000000,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] data,
  input  logic        rc,
  input  logic        freeze,
  output logic [3:0]  an,
  output logic [7:0]  seg,
  output logic        rc_led
);

  localparam int PRE_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int ST_W  = $clog2(STRETCH + 1);

  logic [PRE_W-1:0] r_pre;
  logic [1:0]       r_dig;
  logic [15:0]      r_shadow;
  logic             r_freeze;
  logic             r_rc_q;
  logic [ST_W-1:0]  r_stretch;
  logic [3:0]       r_an;
  logic [7:0]       r_seg;
  logic             r_rc_led;

  logic             w_tick;
  logic             w_rc_rise;
  logic [15:0]      w_upper;
  logic             w_blank;
  logic [6:0]       w_seg7;

  assign w_tick    = (r_pre == PRE_W'(SCAN_DIV - 1));
  assign w_rc_rise = rc & ~r_rc_q;

  // Everything from the current digit upward; nibble select and blanking share it.
  assign w_upper = r_shadow >> {r_dig, 2'b00};
  assign w_blank = BLANK_LZ && (r_dig != 2'd0) && (w_upper == 16'h0000);

  hex_to_seg7 u_hex_to_seg7 (
    .i_nib (w_upper[3:0]),
    .o_seg (w_seg7)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre    <= '0;
      r_dig    <= 2'd0;
      r_shadow <= 16'h0000;
      r_freeze <= 1'b0;
    end else begin
      r_freeze <= freeze;
      if (w_tick) begin
        r_pre <= '0;
        r_dig <= r_dig + 2'd1;
        // Capture only at frame wrap so a frame never mixes two counts.
        if (r_dig == 2'd3 && !r_freeze) begin
          r_shadow <= data;
        end
      end else begin
        r_pre <= r_pre + PRE_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rc_q    <= 1'b0;
      r_stretch <= '0;
      r_rc_led  <= 1'b0;
    end else begin
      r_rc_q <= rc;
      if (w_rc_rise) begin
        r_stretch <= ST_W'(STRETCH);
      end else if (r_stretch != '0) begin
        r_stretch <= r_stretch - ST_W'(1);
      end
      r_rc_led <= (r_stretch != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an  <= AN_OFF;
      r_seg <= SEG_BLANK;
    end else if (w_blank) begin
      r_an  <= AN_OFF;
      r_seg <= SEG_BLANK;
    end else begin
      r_an  <= ~(4'b0001 << r_dig);
      r_seg <= {~((r_dig == 2'd0) && r_freeze), w_seg7};
    end
  end

  assign an     = r_an;
  assign seg    = r_seg;
  assign rc_led = r_rc_led;

endmodule

// File: tb/tb_rev_counter_display.sv
// Self-checking bench for rev_counter_display: per-cycle scoreboard of
// expected an/seg/rc_led plus direct checks of reset and carry pulse shape.
module tb_rev_counter_display;

  localparam int S  = 4;
  localparam int ST = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] data;
  logic        rc;
  logic        freeze;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic        rc_led;

  rev_counter_display #(
    .SCAN_DIV (S),
    .STRETCH  (ST),
    .BLANK_LZ (1'b1)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .data   (data),
    .rc     (rc),
    .freeze (freeze),
    .an     (an),
    .seg    (seg),
    .rc_led (rc_led)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         k;
    logic [3:0] an;
    logic [7:0] seg;
    logic       led;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int n_sb     = 0;

  logic [7:0] seg_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model, phrased in terms of edges since reset release (k).
  int          k          = 0;
  logic [15:0] m_shadow   = 16'h0;
  logic        m_frz      = 1'b0;
  logic        m_rc       = 1'b0;
  int          m_last_rise = -1000;

  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        k = 0;
        m_shadow = 16'h0;
        m_frz = 1'b0;
        m_rc = 1'b0;
        m_last_rise = -1000;
        sb_q.delete();
      end else begin
        exp_t       e;
        int         d;
        logic [3:0] onehot;
        logic [3:0] nib;
        k++;
        d = ((k - 1) / S) % 4;
        e.k = k;
        if (d != 0 && (m_shadow >> (4 * d)) == 16'h0) begin
          e.an  = 4'hF;
          e.seg = 8'hFF;
        end else begin
          onehot = 4'b0001 << d;
          nib    = 4'((m_shadow >> (4 * d)) & 16'h000F);
          e.an   = ~onehot;
          e.seg  = {~(d == 0 && m_frz), seg_tbl[nib][6:0]};
        end
        e.led = (k - m_last_rise >= 1) && (k - m_last_rise <= ST);
        sb_q.push_back(e);
        if (k % (4 * S) == 0 && !m_frz) m_shadow = data;
        if (rc && !m_rc) m_last_rise = k;
        m_frz = freeze;
        m_rc  = rc;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        n_sb++;
        check_eq($sformatf("an@%0d", e.k), {28'h0, an}, {28'h0, e.an});
        check_eq($sformatf("seg@%0d", e.k), {24'h0, seg}, {24'h0, e.seg});
        check_eq($sformatf("rc_led@%0d", e.k), {31'h0, rc_led}, {31'h0, e.led});
      end
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_measure(input int n, input int drop_at, input int re_at,
                               output int first, output int cnt);
    first = -1;
    cnt   = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (rc_led) begin
        cnt++;
        if (first < 0) first = i;
      end
      if (i == drop_at) rc = 1'b0;
      if (i == re_at) rc = 1'b1;
      if (i == re_at + 1) rc = 1'b0;
    end
  endtask

  initial begin
    int first;
    int cnt;
    bit found;
    rst_n  = 1'b1;
    data   = 16'h0000;
    rc     = 1'b0;
    freeze = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("reset_an", {28'h0, an}, 32'hF);
    check_eq("reset_seg", {24'h0, seg}, 32'hFF);
    check_eq("reset_led", {31'h0, rc_led}, 32'h0);
    run(3);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("first_an", {28'h0, an}, 32'hE);
    check_eq("first_seg", {24'h0, seg}, 32'hC0);
    run(40);

    data = 16'h1234;
    run(3 * 4 * S);
    data = 16'h0050;
    run(3 * 4 * S);

    data = 16'h1235;
    run(2 * 4 * S);
    freeze = 1'b1;
    run(1);
    data = 16'hABCD;
    run(4 * 4 * S);
    check_eq("frozen_dp_seen", {31'h0, (seg == 8'h12) || (seg == 8'hB0) || (seg == 8'hA4) || (seg == 8'hF9)}, 32'h1);
    freeze = 1'b0;
    run(3 * 4 * S);

    rc = 1'b1;
    pulse_measure(20, 1, -10, first, cnt);
    check_eq("single_start", first, 2);
    check_eq("single_width", cnt, ST);

    rc = 1'b1;
    pulse_measure(25, 1, 5, first, cnt);
    check_eq("retrig_start", first, 2);
    check_eq("retrig_width", cnt, 5 + ST);

    rc = 1'b1;
    pulse_measure(30, 20, -10, first, cnt);
    check_eq("held_start", first, 2);
    check_eq("held_width", cnt, ST);

    data = 16'hFFFF;
    run(2 * 4 * S);
    found = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (an == 4'b1011) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("wait_dig2", {31'h0, found}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_an", {28'h0, an}, 32'hF);
    check_eq("midrst_seg", {24'h0, seg}, 32'hFF);
    check_eq("midrst_led", {31'h0, rc_led}, 32'h0);
    run(3);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("restart_an", {28'h0, an}, 32'hE);
    check_eq("restart_seg", {24'h0, seg}, 32'hC0);
    run(3 * 4 * S);

    check_eq("sb_active", {31'h0, n_sb > 300}, 32'h1);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
